// File: rtl/press_pulse_generator.sv
// press_pulse_generator
// Emits a train of button-style presses on button_out: each press is high for
// max(high_len,1) cycles followed by a low gap of max(low_len,1) cycles.
// Optional build macro PRESS_BOUNCE_EN prefixes every press with a
// BOUNCE_CYCLES-long burst of alternating 1/0 glitches.
//
// Handshake: there is no ready signal. start is sampled only while the FSM is
// in IDLE (busy=0). An accepted start latches count/high_len/low_len. A start
// seen while busy=1 is dropped. done pulses for one cycle when a train ends,
// and a new start may be presented in that same cycle.
module press_pulse_generator #(
    parameter int N             = 4,
    parameter int W             = 8,
    parameter int BOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [N-1:0] count,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    output logic         button_out,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sent,
    output logic [1:0]   state_dbg
);

`ifdef PRESS_BOUNCE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, BOUNCE = 2'd3} state_t;
    localparam logic [W-1:0] BOUNCE_LAST = W'(BOUNCE_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;
    logic unused_bounce_cfg;
    assign unused_bounce_cfg = (BOUNCE_CYCLES != 0);
`endif

    state_t       state, state_next;
    logic [W-1:0] timer, timer_next;     // cycles left in the current phase, minus one
    logic [N-1:0] count_q;
    logic [W-1:0] high_q, low_q;
    logic [N-1:0] sent_next;
    logic         button_next;
    logic         done_next;
    logic         load;                  // accepted start: capture operands
    logic         press;                 // begin a new press this cycle

`ifndef PRESS_BOUNCE_EN
    // Without the bounce burst the first press enters HIGH straight from IDLE,
    // before the operands are latched, so take the length from the inputs then.
    logic [W-1:0] press_len;
    assign press_len = (state == IDLE) ? high_len : high_q;
`endif

    // Phase length of zero behaves as one cycle; timer holds length-1.
    function automatic logic [W-1:0] last_tick(input logic [W-1:0] len);
        return (len == '0) ? '0 : len - W'(1);
    endfunction

    // Next-state, phase timer and registered-output decode.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        sent_next   = sent;
        button_next = 1'b0;
        done_next   = 1'b0;
        load        = 1'b0;
        press       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    sent_next = '0;
                    if (count != '0) begin
                        press     = 1'b1;
                        sent_next = N'(1);
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (timer == '0) begin
                    state_next = LOW;
                    timer_next = last_tick(low_q);
                end else begin
                    button_next = 1'b1;
                    timer_next  = timer - W'(1);
                end
            end
            LOW: begin
                if (timer != '0) begin
                    timer_next = timer - W'(1);
                end else if (sent != count_q) begin
                    press     = 1'b1;
                    sent_next = sent + N'(1);
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
`ifdef PRESS_BOUNCE_EN
            BOUNCE: begin
                if (timer == '0) begin
                    state_next  = HIGH;
                    timer_next  = last_tick(high_q);
                    button_next = 1'b1;
                end else begin
                    timer_next  = timer - W'(1);
                    button_next = ~button_out;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
        if (press) begin
`ifdef PRESS_BOUNCE_EN
            state_next = BOUNCE;
            timer_next = BOUNCE_LAST;
`else
            state_next = HIGH;
            timer_next = last_tick(press_len);
`endif
            button_next = 1'b1;
        end
    end

    // State, timer, operand latches and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            timer      <= '0;
            count_q    <= '0;
            high_q     <= '0;
            low_q      <= '0;
            sent       <= '0;
            button_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            sent       <= sent_next;
            button_out <= button_next;
            done       <= done_next;
            if (load) begin
                count_q <= count;
                high_q  <= high_len;
                low_q   <= low_len;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_press_pulse_generator.sv
// Bench for press_pulse_generator: per-cycle expected {done,busy,button_out,sent}
// words are queued from a timing model when a train is launched and popped
// against the DUT on each falling edge.
`timescale 1ns/1ps
module tb_press_pulse_generator;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BC = 4;
    localparam int VW = N + 3;
`ifdef PRESS_BOUNCE_EN
    localparam int BCX = BC;
`else
    localparam int BCX = 0;
`endif

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] count = '0;
    logic [W-1:0] high_len = '0;
    logic [W-1:0] low_len = '0;
    logic         button_out;
    logic         busy;
    logic         done;
    logic [N-1:0] sent;
    logic [1:0]   state_dbg;

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] got;
    logic [VW-1:0] want;
    int n_compared = 0;
    int n_mismatched = 0;

    press_pulse_generator #(.N(N), .W(W), .BOUNCE_CYCLES(BC)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .count(count),
        .high_len(high_len), .low_len(low_len), .button_out(button_out),
        .busy(busy), .done(done), .sent(sent), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] pack_exp(input logic d, input logic b,
                                               input logic btn, input logic [N-1:0] s);
        return {d, b, btn, s};
    endfunction

    // Timing model: press k occupies [bounce] H high then L low cycles.
    task automatic push_train(input int cnt, input int h, input int l);
        int hh;
        int ll;
        hh = (h == 0) ? 1 : h;
        ll = (l == 0) ? 1 : l;
        if (cnt == 0) begin
            exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, '0));
        end else begin
            for (int k = 1; k <= cnt; k++) begin
                for (int b = 0; b < BCX; b++)
                    exp_q.push_back(pack_exp(1'b0, 1'b1, (b % 2 == 0), N'(k)));
                repeat (hh) exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, N'(k)));
                repeat (ll) exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b0, N'(k)));
            end
            exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, N'(cnt)));
        end
    endtask

    task automatic launch(input int cnt, input int h, input int l);
        @(negedge clk);
        start    = 1'b1;
        count    = N'(cnt);
        high_len = W'(h);
        low_len  = W'(l);
        push_train(cnt, h, l);
    endtask

    task automatic test_reset();
        clr_n    = 1'b0;
        start    = 1'b1;
        count    = 4'd5;
        high_len = 8'd3;
        low_len  = 8'd3;
        repeat (3) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            n_compared++;
            if (got !== want || state_dbg !== 2'd0) begin
                n_mismatched++;
                $display("FAIL reset cycle %0d: got %h st %0d want %h st 0", i, got, state_dbg, want);
            end
        end
        clr_n = 1'b1;
        start = 1'b0;
        repeat (2) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            n_compared++;
            if (got !== want || state_dbg !== 2'd0) begin
                n_mismatched++;
                $display("FAIL reset_release cycle %0d: got %h st %0d want %h st 0", i, got, state_dbg, want);
            end
        end
    endtask

    task automatic test_basic();
        launch(3, 2, 1);
        repeat (2) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, 4'd3));
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL basic cycle %0d: got %h want %h", i + 1, got, want);
            end
        end
    endtask

    task automatic test_count_zero();
        launch(0, 5, 5);
        repeat (3) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL count_zero cycle %0d: got %h want %h", i + 1, got, want);
            end
        end
    endtask

    task automatic test_zero_len();
        launch(2, 0, 0);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL zero_len cycle %0d: got %h want %h", i + 1, got, want);
            end
        end
    endtask

    task automatic test_random_trains();
        for (int t = 0; t < 3; t++) begin
            launch($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int i = 0; i < 500 && exp_q.size() > 0; i++) begin
                @(negedge clk);
                got = {done, busy, button_out, sent};
                want = exp_q.pop_front();
                start = 1'b0;
                n_compared++;
                if (got !== want) begin
                    n_mismatched++;
                    $display("FAIL random%0d cycle %0d: got %h want %h", t, i + 1, got, want);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        launch(2, 1, 1);
        repeat (2) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, 4'd2));
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL busy_ignore cycle %0d: got %h want %h", i + 1, got, want);
            end
            if (i == 1) begin
                start    = 1'b1;
                count    = 4'd5;
                high_len = 8'd9;
                low_len  = 8'd7;
            end
        end
    endtask

    task automatic test_back_to_back();
        int len_a;
        launch(1, 1, 1);
        len_a = exp_q.size();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", i + 1, got, want);
            end
            if (i == len_a - 1) begin
                start    = 1'b1;
                count    = 4'd2;
                high_len = 8'd1;
                low_len  = 8'd2;
                push_train(2, 1, 2);
                exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, 4'd2));
            end
        end
    endtask

    task automatic test_reset_mid_train();
        int c2;
        launch(4, 2, 1);
        c2 = 1 + (BCX + 3) + BCX;
        for (int i = 0; i < c2; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL midrst_pre cycle %0d: got %h want %h", i + 1, got, want);
            end
        end
        #1 clr_n = 1'b0;
        #1;
        n_compared++;
        if (button_out !== 1'b0 || sent !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midrst_async: got btn %b sent %0d busy %b done %b want all 0",
                     button_out, sent, busy, done);
        end
        exp_q.delete();
        repeat (2) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL midrst_hold cycle %0d: got %h want %h", i, got, want);
            end
        end
        clr_n = 1'b1;
        repeat (4) exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL midrst_after cycle %0d: got %h want %h", i, got, want);
            end
        end
    endtask

`ifdef PRESS_BOUNCE_EN
    task automatic test_bounce();
        logic btn_seq [7];
        btn_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        start    = 1'b1;
        count    = 4'd1;
        high_len = 8'd2;
        low_len  = 8'd1;
        for (int k = 0; k < 7; k++) exp_q.push_back(pack_exp(1'b0, 1'b1, btn_seq[k], 4'd1));
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 4'd1));
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            got = {done, busy, button_out, sent};
            want = exp_q.pop_front();
            start = 1'b0;
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("FAIL bounce cycle %0d: got %h want %h", i + 1, got, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_count_zero();
        test_zero_len();
        test_random_trains();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_train();
`ifdef PRESS_BOUNCE_EN
        test_bounce();
`endif
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
